// File: rtl/fu_jump_pipe.sv
// Branch/JAL/JALR functional unit: captures one issue, resolves direction,
// target, link value and mispredict after LATENCY cycles, tagged on completion.
module fu_jump_pipe #(
  parameter int XLEN        = 32,
  parameter int LATENCY     = 1,
  parameter int TAG_W       = 4,
  parameter int ALIGN_CHECK = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             EN,
  output logic             ready,
  input  logic             JALR,
  input  logic [2:0]       cmp_ctrl,
  input  logic [XLEN-1:0]  rs1_data,
  input  logic [XLEN-1:0]  rs2_data,
  input  logic [XLEN-1:0]  imm,
  input  logic [XLEN-1:0]  PC,
  input  logic             pred_taken,
  input  logic [XLEN-1:0]  pred_target,
  input  logic [TAG_W-1:0] tag_in,
  output logic             done,
  output logic [TAG_W-1:0] tag_out,
  output logic             cmp_res,
  output logic             taken,
  output logic [XLEN-1:0]  PC_jump,
  output logic [XLEN-1:0]  PC_wb,
  output logic             misalign,
  output logic             redirect
);

  localparam logic [2:0] CNT_LOAD = 3'(LATENCY - 1);
  localparam logic       ALIGN_EN = (ALIGN_CHECK != 0);

  logic             busy_q, busy_d;
  logic [2:0]       cnt_q, cnt_d;
  logic             jalr_q, jalr_d;
  logic [2:0]       cmp_q, cmp_d;
  logic [XLEN-1:0]  rs1_q, rs1_d;
  logic [XLEN-1:0]  rs2_q, rs2_d;
  logic [XLEN-1:0]  imm_q, imm_d;
  logic [XLEN-1:0]  pc_q, pc_d;
  logic             pred_taken_q, pred_taken_d;
  logic [XLEN-1:0]  pred_target_q, pred_target_d;
  logic [TAG_W-1:0] tag_q, tag_d;

  logic             accept;
  logic [XLEN-1:0]  base;
  logic [XLEN-1:0]  sum;

  // A completing instruction frees the slot in the same cycle, so issues can run back-to-back.
  assign done   = busy_q & (cnt_q == 3'd0);
  assign ready  = ~busy_q | done;
  assign accept = EN & ready;

  // Next-state: capture on accepted issue, otherwise count down or retire.
  always_comb begin
    busy_d        = busy_q;
    cnt_d         = cnt_q;
    jalr_d        = jalr_q;
    cmp_d         = cmp_q;
    rs1_d         = rs1_q;
    rs2_d         = rs2_q;
    imm_d         = imm_q;
    pc_d          = pc_q;
    pred_taken_d  = pred_taken_q;
    pred_target_d = pred_target_q;
    tag_d         = tag_q;
    if (accept) begin
      busy_d        = 1'b1;
      cnt_d         = CNT_LOAD;
      jalr_d        = JALR;
      cmp_d         = cmp_ctrl;
      rs1_d         = rs1_data;
      rs2_d         = rs2_data;
      imm_d         = imm;
      pc_d          = PC;
      pred_taken_d  = pred_taken;
      pred_target_d = pred_target;
      tag_d         = tag_in;
    end else if (busy_q && (cnt_q != 3'd0)) begin
      cnt_d = cnt_q - 3'd1;
    end else begin
      busy_d = 1'b0;
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      busy_q        <= 1'b0;
      cnt_q         <= 3'd0;
      jalr_q        <= 1'b0;
      cmp_q         <= 3'd0;
      rs1_q         <= '0;
      rs2_q         <= '0;
      imm_q         <= '0;
      pc_q          <= '0;
      pred_taken_q  <= 1'b0;
      pred_target_q <= '0;
      tag_q         <= '0;
    end else begin
      busy_q        <= busy_d;
      cnt_q         <= cnt_d;
      jalr_q        <= jalr_d;
      cmp_q         <= cmp_d;
      rs1_q         <= rs1_d;
      rs2_q         <= rs2_d;
      imm_q         <= imm_d;
      pc_q          <= pc_d;
      pred_taken_q  <= pred_taken_d;
      pred_target_q <= pred_target_d;
      tag_q         <= tag_d;
    end
  end

  // Results are derived from the captured operands, so they hold between completions.
  always_comb begin
    base    = jalr_q ? rs1_q : pc_q;
    sum     = base + imm_q;
    PC_jump = sum;
    if (jalr_q) begin
      PC_jump[0] = 1'b0;
    end else begin
      PC_jump[0] = sum[0];
    end
    PC_wb = pc_q + XLEN'(4);
    case (cmp_q)
      3'b000:  cmp_res = 1'b0;
      3'b001:  cmp_res = (rs1_q == rs2_q);
      3'b010:  cmp_res = (rs1_q != rs2_q);
      3'b011:  cmp_res = ($signed(rs1_q) < $signed(rs2_q));
      3'b100:  cmp_res = (rs1_q < rs2_q);
      3'b101:  cmp_res = ($signed(rs1_q) >= $signed(rs2_q));
      3'b110:  cmp_res = (rs1_q >= rs2_q);
      3'b111:  cmp_res = 1'b1;
      default: cmp_res = 1'b0;
    endcase
    taken    = cmp_res;
    misalign = ALIGN_EN & taken & (PC_jump[1:0] != 2'b00);
    redirect = (taken != pred_taken_q) | (taken & (PC_jump != pred_target_q));
    tag_out  = tag_q;
  end

endmodule

// File: tb/tb_fu_jump_pipe.sv
// Bench for fu_jump_pipe: two instances (LATENCY=1/ALIGN_CHECK=1 and
// LATENCY=3/ALIGN_CHECK=0) on shared inputs, checked against a cycle-count model.
module tb_fu_jump_pipe;

  typedef struct packed {
    logic        jalr;
    logic [2:0]  cmp;
    logic [31:0] rs1;
    logic [31:0] rs2;
    logic [31:0] imm;
    logic [31:0] pc;
    logic        pt;
    logic [31:0] ptg;
    logic [3:0]  tag;
  } instr_t;

  typedef struct packed {
    logic        taken;
    logic [31:0] jump;
    logic [31:0] wb;
    logic        mis;
    logic        redir;
  } res_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, en, jalr, pred_taken;
  logic [2:0]  cmp_ctrl;
  logic [31:0] rs1, rs2, imm, pc, pred_target;
  logic [3:0]  tag_in;

  logic [1:0]  done_w, ready_w, cmp_w, taken_w, mis_w, redir_w;
  logic [3:0]  tag_w  [2];
  logic [31:0] jump_w [2];
  logic [31:0] wb_w   [2];

  fu_jump_pipe #(.XLEN(32), .LATENCY(1), .TAG_W(4), .ALIGN_CHECK(1)) dut_a (
    .clk(clk), .rst(rst), .EN(en), .ready(ready_w[0]), .JALR(jalr), .cmp_ctrl(cmp_ctrl),
    .rs1_data(rs1), .rs2_data(rs2), .imm(imm), .PC(pc), .pred_taken(pred_taken),
    .pred_target(pred_target), .tag_in(tag_in), .done(done_w[0]), .tag_out(tag_w[0]),
    .cmp_res(cmp_w[0]), .taken(taken_w[0]), .PC_jump(jump_w[0]), .PC_wb(wb_w[0]),
    .misalign(mis_w[0]), .redirect(redir_w[0])
  );

  fu_jump_pipe #(.XLEN(32), .LATENCY(3), .TAG_W(4), .ALIGN_CHECK(0)) dut_b (
    .clk(clk), .rst(rst), .EN(en), .ready(ready_w[1]), .JALR(jalr), .cmp_ctrl(cmp_ctrl),
    .rs1_data(rs1), .rs2_data(rs2), .imm(imm), .PC(pc), .pred_taken(pred_taken),
    .pred_target(pred_target), .tag_in(tag_in), .done(done_w[1]), .tag_out(tag_w[1]),
    .cmp_res(cmp_w[1]), .taken(taken_w[1]), .PC_jump(jump_w[1]), .PC_wb(wb_w[1]),
    .misalign(mis_w[1]), .redirect(redir_w[1])
  );

  int n_chk  = 0;
  int n_pass = 0;

  // Reference model state: last captured instruction and the cycle it was captured in.
  instr_t rec_m [2];
  bit     pend_m [2];
  int     cap_m [2];
  int     lat_m [2] = '{1, 3};
  bit     al_m [2]  = '{1'b1, 1'b0};
  string  nm [2]    = '{"a", "b"};
  int     cyc = 0;

  int          done_cyc_q [$];
  logic [3:0]  done_tag_q [$];

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  function automatic res_t ref_result(input instr_t i, input bit align);
    res_t r;
    longint unsigned base, tgt;
    base = i.jalr ? {32'd0, i.rs1} : {32'd0, i.pc};
    tgt  = (base + {32'd0, i.imm}) % 64'h1_0000_0000;
    if (i.jalr) tgt = tgt - (tgt % 64'd2);
    case (i.cmp)
      3'd0:    r.taken = 1'b0;
      3'd1:    r.taken = (i.rs1 == i.rs2);
      3'd2:    r.taken = (i.rs1 != i.rs2);
      3'd3:    r.taken = (int'(i.rs1) < int'(i.rs2));
      3'd4:    r.taken = ({32'd0, i.rs1} < {32'd0, i.rs2});
      3'd5:    r.taken = !(int'(i.rs1) < int'(i.rs2));
      3'd6:    r.taken = !({32'd0, i.rs1} < {32'd0, i.rs2});
      default: r.taken = 1'b1;
    endcase
    r.jump  = tgt[31:0];
    r.wb    = 32'(({32'd0, i.pc} + 64'd4) % 64'h1_0000_0000);
    r.mis   = align && r.taken && ((r.jump % 32'd4) != 32'd0);
    r.redir = (r.taken != i.pt) || (r.taken && (r.jump != i.ptg));
    return r;
  endfunction

  task automatic step(input bit r, input bit e, input instr_t i, output bit acc_b);
    bit   done_e [2];
    bit   rdy_e [2];
    res_t x;
    rst = r; en = e; jalr = i.jalr; cmp_ctrl = i.cmp; rs1 = i.rs1; rs2 = i.rs2;
    imm = i.imm; pc = i.pc; pred_taken = i.pt; pred_target = i.ptg; tag_in = i.tag;
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      done_e[k] = pend_m[k] && ((cyc - cap_m[k]) == lat_m[k] - 1);
      rdy_e[k]  = !pend_m[k] || done_e[k];
      x = ref_result(rec_m[k], al_m[k]);
      check_val({nm[k], "_done"},  32'(done_w[k]),  32'(done_e[k]));
      check_val({nm[k], "_ready"}, 32'(ready_w[k]), 32'(rdy_e[k]));
      check_val({nm[k], "_tag"},   32'(tag_w[k]),   32'(rec_m[k].tag));
      check_val({nm[k], "_cmp"},   32'(cmp_w[k]),   32'(x.taken));
      check_val({nm[k], "_taken"}, 32'(taken_w[k]), 32'(x.taken));
      check_val({nm[k], "_jump"},  jump_w[k],       x.jump);
      check_val({nm[k], "_wb"},    wb_w[k],         x.wb);
      check_val({nm[k], "_mis"},   32'(mis_w[k]),   32'(x.mis));
      check_val({nm[k], "_redir"}, 32'(redir_w[k]), 32'(x.redir));
    end
    if (done_w[1]) begin
      done_cyc_q.push_back(cyc);
      done_tag_q.push_back(tag_w[1]);
    end
    acc_b = !r && e && rdy_e[1];
    @(posedge clk);
    for (int k = 0; k < 2; k++) begin
      if (r) begin
        rec_m[k]  = '0;
        pend_m[k] = 1'b0;
      end else if (e && rdy_e[k]) begin
        rec_m[k]  = i;
        pend_m[k] = 1'b1;
        cap_m[k]  = cyc + 1;
      end else if (done_e[k]) begin
        pend_m[k] = 1'b0;
      end
    end
    cyc++;
    #1;
  endtask

  function automatic instr_t mk(input bit j, input logic [2:0] c, input logic [31:0] a,
                                input logic [31:0] b, input logic [31:0] im, input logic [31:0] p,
                                input bit pt, input logic [31:0] ptg, input logic [3:0] t);
    instr_t i;
    i.jalr = j; i.cmp = c; i.rs1 = a; i.rs2 = b; i.imm = im; i.pc = p;
    i.pt = pt; i.ptg = ptg; i.tag = t;
    return i;
  endfunction

  task automatic idle(input int n);
    bit acc;
    for (int q = 0; q < n; q++) step(1'b0, 1'b0, '0, acc);
  endtask

  initial begin
    instr_t cur;
    bit     acc;
    int     t;
    logic [9:0] b10;

    rst = 1'b1; en = 1'b0; jalr = 1'b0; cmp_ctrl = 3'd0; rs1 = '0; rs2 = '0; imm = '0;
    pc = '0; pred_taken = 1'b0; pred_target = '0; tag_in = '0;
    for (int k = 0; k < 2; k++) begin
      rec_m[k] = '0; pend_m[k] = 1'b0; cap_m[k] = 0;
    end
    @(posedge clk); #1;
    step(1'b1, 1'b0, '0, acc);
    for (int k = 0; k < 2; k++) begin
      check_val({nm[k], "_rst_ready"}, 32'(ready_w[k]), 32'd1);
      check_val({nm[k], "_rst_wb"},    wb_w[k],         32'h4);
      check_val({nm[k], "_rst_jump"},  jump_w[k],       32'h0);
    end

    // Held issue: BEQ first, then JALs; dut_b takes one per 3 cycles.
    t = 1;
    for (int n = 0; n < 20 && t <= 3; n++) begin
      if (t == 1) cur = mk(1'b0, 3'b001, 32'd5, 32'd5, 32'h20, 32'h100, 1'b1, 32'h120, 4'd1);
      else        cur = mk(1'b0, 3'b111, 32'd0, 32'd0, 32'h40, 32'h200 * t, 1'b1, 32'h200 * t + 32'h40, 4'(t));
      step(1'b0, 1'b1, cur, acc);
      if (n == 0) begin
        check_val("beq_done",  32'(done_w[0]),  32'd1);
        check_val("beq_taken", 32'(taken_w[0]), 32'd1);
        check_val("beq_jump",  jump_w[0],       32'h120);
        check_val("beq_wb",    wb_w[0],         32'h104);
        check_val("beq_redir", 32'(redir_w[0]), 32'd0);
        check_val("b_busy",    32'(ready_w[1]), 32'd0);
      end
      if (acc) t++;
    end
    idle(4);
    check_val("b_done_count", 32'(done_tag_q.size()), 32'd3);
    if (done_tag_q.size() == 3) begin
      for (int q = 0; q < 3; q++) check_val("b_done_tag", 32'(done_tag_q[q]), 32'(q + 1));
      check_val("b_done_gap1", 32'(done_cyc_q[1] - done_cyc_q[0]), 32'd3);
      check_val("b_done_gap2", 32'(done_cyc_q[2] - done_cyc_q[1]), 32'd3);
    end

    step(1'b0, 1'b1, mk(1'b0, 3'b011, 32'hFFFF_FFFF, 32'd1, 32'h10, 32'h300, 1'b0, 32'h0, 4'd4), acc);
    check_val("blt_taken", 32'(taken_w[0]), 32'd1);
    idle(3);
    step(1'b0, 1'b1, mk(1'b0, 3'b100, 32'hFFFF_FFFF, 32'd1, 32'h10, 32'h300, 1'b1, 32'h310, 4'd5), acc);
    check_val("bltu_taken", 32'(taken_w[0]), 32'd0);
    check_val("bltu_redir", 32'(redir_w[0]), 32'd1);
    idle(3);
    step(1'b0, 1'b1, mk(1'b1, 3'b111, 32'h2003, 32'd0, 32'h0, 32'h400, 1'b1, 32'h2002, 4'd6), acc);
    check_val("jalr_jump", jump_w[0],     32'h2002);
    check_val("jalr_mis",  32'(mis_w[0]), 32'd1);
    idle(3);
    check_val("jalr_mis_noalign", 32'(mis_w[1]), 32'd0);
    step(1'b0, 1'b1, mk(1'b0, 3'b111, 32'd0, 32'd0, 32'h8, 32'hFFFF_FFFC, 1'b1, 32'h4, 4'd7), acc);
    check_val("wrap_jump", jump_w[0], 32'h4);
    check_val("wrap_wb",   wb_w[0],   32'h0);
    idle(3);

    // Reset lands while dut_b's JAL is one cycle from completion.
    step(1'b0, 1'b1, mk(1'b0, 3'b111, 32'd0, 32'd0, 32'h80, 32'h500, 1'b1, 32'h580, 4'd8), acc);
    step(1'b0, 1'b0, '0, acc);
    step(1'b1, 1'b0, '0, acc);
    check_val("abort_done",  32'(done_w[1]),  32'd0);
    check_val("abort_ready", 32'(ready_w[1]), 32'd1);
    check_val("abort_wb",    wb_w[1],         32'h4);
    idle(3);

    for (int n = 0; n < 400; n++) begin
      b10      = 10'($urandom);
      cur.jalr = 1'($urandom);
      cur.cmp  = 3'($urandom);
      cur.rs1  = $urandom;
      cur.rs2  = ($urandom_range(0, 3) == 0) ? cur.rs1 : $urandom;
      cur.imm  = {{22{b10[9]}}, b10};
      cur.pc   = ($urandom_range(0, 7) == 0) ? $urandom : ($urandom & 32'hFFFF_FFFC);
      cur.pt   = 1'($urandom);
      cur.ptg  = 32'h0;
      cur.tag  = 4'($urandom);
      cur.ptg  = ($urandom_range(0, 1) == 0) ? ref_result(cur, 1'b1).jump : $urandom;
      step(($urandom_range(0, 39) == 0), ($urandom_range(0, 9) < 6), cur, acc);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
